// File: rtl/decode_stage_p_if.sv
// Fetch-to-decode-to-execute bundle, writeback port and status for the decode stage.
// The slave side belongs to the decode stage; the master side drives it.
interface decode_stage_p_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;
    logic [DATA_W-1:0] in_pc;
    logic              wb_en;
    logic [2:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [DATA_W-1:0] out_imm;
    logic [2:0]        out_dest;
    logic              out_dest_en;
    logic [15:0]       out_instr;
    logic [DATA_W-1:0] out_pc;
    logic              err;

    modport slave (
        input  in_valid, in_instr, in_pc, wb_en, wb_reg, wb_data, flush, out_ready,
        output in_ready, out_valid, out_rs_data, out_rt_data, out_imm, out_dest,
               out_dest_en, out_instr, out_pc, err
    );

    modport master (
        output in_valid, in_instr, in_pc, wb_en, wb_reg, wb_data, flush, out_ready,
        input  in_ready, out_valid, out_rs_data, out_rt_data, out_imm, out_dest,
               out_dest_en, out_instr, out_pc, err
    );
endinterface

// File: rtl/decode_stage_p.sv
// Pipelined decode stage: register file, field decode, RAW scoreboard with stall,
// and a single registered valid/ready output stage toward execute.
module decode_stage_p #(
    parameter int DATA_W = 16,
    parameter int SB_W   = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_p_if.slave bus
);
    localparam logic [SB_W-1:0] SB_MAX = '1;

    logic [DATA_W-1:0] r_rf [8];
    logic [SB_W-1:0]   r_sb [8];

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_rs_data;
    logic [DATA_W-1:0] r_out_rt_data;
    logic [DATA_W-1:0] r_out_imm;
    logic [2:0]        r_out_dest;
    logic              r_out_dest_en;
    logic [15:0]       r_out_instr;
    logic [DATA_W-1:0] r_out_pc;
    logic              r_err;

    logic [2:0]        w_op3;
    logic [4:0]        w_op5;
    logic [2:0]        w_rs;
    logic [2:0]        w_rt;
    logic [2:0]        w_dest;
    logic              w_dest_en;
    logic [DATA_W-1:0] w_imm;
    logic              w_byp_rs;
    logic              w_byp_rt;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic              w_busy_rs;
    logic              w_busy_rt;
    logic              w_stall;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_out_fire;
    logic              w_inc_any;
    logic [7:0]        w_inc;
    logic [7:0]        w_dec;
    logic              w_err_set;

    assign w_op3 = bus.in_instr[15:13];
    assign w_op5 = bus.in_instr[15:11];
    assign w_rs  = bus.in_instr[10:8];
    assign w_rt  = bus.in_instr[7:5];

    always_comb begin
        w_dest = bus.in_instr[10:8];
        if (w_op5 == 5'b11011) begin
            w_dest = bus.in_instr[4:2];
        end else if (w_op3 == 3'b010 || w_op3 == 3'b101) begin
            w_dest = bus.in_instr[7:5];
        end
    end

    assign w_imm = (w_op3 == 3'b110 || w_op3 == 3'b001)
                 ? {{(DATA_W-8){bus.in_instr[7]}}, bus.in_instr[7:0]}
                 : {{(DATA_W-5){bus.in_instr[4]}}, bus.in_instr[4:0]};

    assign w_dest_en = !(w_op3 == 3'b011 || w_op5 == 5'b00000 || w_op5 == 5'b10000);

    assign w_byp_rs  = BYPASS && bus.wb_en && (bus.wb_reg == w_rs);
    assign w_byp_rt  = BYPASS && bus.wb_en && (bus.wb_reg == w_rt);
    assign w_rs_data = w_byp_rs ? bus.wb_data : r_rf[w_rs];
    assign w_rt_data = w_byp_rt ? bus.wb_data : r_rf[w_rt];

    // A writeback retiring in this same cycle discounts one pending writer when forwarding.
    assign w_busy_rs = (r_sb[w_rs] > {{(SB_W-1){1'b0}}, w_byp_rs})
                    || (r_out_valid && r_out_dest_en && (r_out_dest == w_rs));
    assign w_busy_rt = (r_sb[w_rt] > {{(SB_W-1){1'b0}}, w_byp_rt})
                    || (r_out_valid && r_out_dest_en && (r_out_dest == w_rt));
    assign w_stall   = w_busy_rs || w_busy_rt;

    assign w_in_ready = (!r_out_valid || bus.out_ready) && !w_stall && !bus.flush;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready && !bus.flush;
    assign w_inc_any  = w_out_fire && r_out_dest_en;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < 8; i++) begin
            w_inc[i] = w_inc_any && (r_out_dest == 3'(i));
            w_dec[i] = bus.wb_en && (bus.wb_reg == 3'(i));
        end
    end

    assign w_err_set = (bus.wb_en && (r_sb[bus.wb_reg] == '0))
                    || (w_inc_any && !w_dec[r_out_dest] && (r_sb[r_out_dest] == SB_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else if (bus.wb_en) begin
            r_rf[bus.wb_reg] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_sb[i] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    if (r_sb[i] != SB_MAX) r_sb[i] <= r_sb[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i]) begin
                    if (r_sb[i] != '0) r_sb[i] <= r_sb[i] - 1'b1;
                end
            end
            r_err <= r_err | w_err_set;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid   <= 1'b0;
            r_out_rs_data <= '0;
            r_out_rt_data <= '0;
            r_out_imm     <= '0;
            r_out_dest    <= '0;
            r_out_dest_en <= 1'b0;
            r_out_instr   <= '0;
            r_out_pc      <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_rs_data <= w_rs_data;
            r_out_rt_data <= w_rt_data;
            r_out_imm     <= w_imm;
            r_out_dest    <= w_dest;
            r_out_dest_en <= w_dest_en;
            r_out_instr   <= bus.in_instr;
            r_out_pc      <= bus.in_pc;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_rs_data = r_out_rs_data;
    assign bus.out_rt_data = r_out_rt_data;
    assign bus.out_imm     = r_out_imm;
    assign bus.out_dest    = r_out_dest;
    assign bus.out_dest_en = r_out_dest_en;
    assign bus.out_instr   = r_out_instr;
    assign bus.out_pc      = r_out_pc;
    assign bus.err         = r_err;
endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: a forwarding and a non-forwarding instance
// share one stimulus; decode table plus hand sequences for stall, hold, flush, err.
module tb_decode_stage_p;
    logic        clk;
    logic        rst_n;
    logic        iv1;
    logic        iv0;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        flush;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    decode_stage_p_if #(.DATA_W(16)) if_b1 ();
    decode_stage_p_if #(.DATA_W(16)) if_b0 ();

    assign if_b1.in_valid  = iv1;
    assign if_b0.in_valid  = iv0;
    assign if_b1.in_instr  = instr;
    assign if_b0.in_instr  = instr;
    assign if_b1.in_pc     = pc;
    assign if_b0.in_pc     = pc;
    assign if_b1.wb_en     = wb_en;
    assign if_b0.wb_en     = wb_en;
    assign if_b1.wb_reg    = wb_reg;
    assign if_b0.wb_reg    = wb_reg;
    assign if_b1.wb_data   = wb_data;
    assign if_b0.wb_data   = wb_data;
    assign if_b1.flush     = flush;
    assign if_b0.flush     = flush;
    assign if_b1.out_ready = out_ready;
    assign if_b0.out_ready = out_ready;

    decode_stage_p #(.DATA_W(16), .SB_W(2), .BYPASS(1'b1)) u_b1 (
        .clk (clk),
        .rst (rst_n),
        .bus (if_b1.slave)
    );

    decode_stage_p #(.DATA_W(16), .SB_W(2), .BYPASS(1'b0)) u_b0 (
        .clk (clk),
        .rst (rst_n),
        .bus (if_b0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [15:0] imm;
        logic [2:0]  dest;
        logic        dest_en;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        iv1       = 1'b0;
        iv0       = 1'b0;
        instr     = '0;
        pc        = '0;
        wb_en     = 1'b0;
        wb_reg    = '0;
        wb_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [15:0] pv(input int i);
        return 16'(32'h1000 * (i + 1) + i);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'hC2FF, 3'd2, 3'd7, 16'hFFFF, 3'd2, 1'b1};
        vecs[1] = '{16'h2B7F, 3'd3, 3'd3, 16'h007F, 3'd3, 1'b1};
        vecs[2] = '{16'hDB9C, 3'd3, 3'd4, 16'hFF9C, 3'd7, 1'b1};
        vecs[3] = '{16'hA5F0, 3'd5, 3'd7, 16'hFFF0, 3'd7, 1'b1};
        vecs[4] = '{16'h6A4F, 3'd2, 3'd2, 16'h000F, 3'd2, 1'b0};
        vecs[5] = '{16'h0123, 3'd1, 3'd1, 16'h0003, 3'd1, 1'b0};
        vecs[6] = '{16'h8611, 3'd6, 3'd0, 16'hFFF1, 3'd6, 1'b0};
        vecs[7] = '{16'hE4B5, 3'd4, 3'd5, 16'hFFF5, 3'd4, 1'b1};
        vecs[8] = '{16'h3880, 3'd0, 3'd4, 16'hFF80, 3'd0, 1'b1};
        vecs[9] = '{16'h4000, 3'd0, 3'd0, 16'h0000, 3'd0, 1'b1};

        // Reset state and first bundle
        do_reset();
        smp();
        chk("rst out_valid", if_b1.out_valid, 0);
        chk("rst err", if_b1.err, 0);
        chk("rst rs_data", if_b1.out_rs_data, 0);
        chk("rst dest_en", if_b1.out_dest_en, 0);
        chk("rst in_ready", if_b1.in_ready, 1);
        instr = 16'h4000; pc = 16'h0002; iv1 = 1; iv0 = 1; out_ready = 1;
        step();
        iv1 = 0; iv0 = 0;
        smp();
        chk("first out_valid", if_b1.out_valid, 1);
        chk("first rs_data", if_b1.out_rs_data, 0);
        chk("first imm", if_b1.out_imm, 0);
        chk("first pc", if_b1.out_pc, 16'h0002);
        chk("first err", if_b1.err, 0);
        step();
        smp();
        chk("first drained", if_b1.out_valid, 0);

        // Decode table over a preloaded register file
        for (int k = 0; k < 10; k++) begin
            do_reset();
            for (int r = 0; r < 8; r++) begin
                wb_en = 1; wb_reg = 3'(r); wb_data = pv(r);
                step();
            end
            wb_en = 0;
            instr = vecs[k].instr; pc = 16'h0100 + 16'(2 * k);
            iv1 = 1; iv0 = 1; out_ready = 0;
            smp();
            chk($sformatf("vec%0d in_ready", k), if_b1.in_ready, 1);
            step();
            iv1 = 0; iv0 = 0;
            smp();
            chk($sformatf("vec%0d out_valid", k), if_b1.out_valid, 1);
            chk($sformatf("vec%0d rs_data", k), if_b1.out_rs_data, pv(int'(vecs[k].rs)));
            chk($sformatf("vec%0d rt_data", k), if_b1.out_rt_data, pv(int'(vecs[k].rt)));
            chk($sformatf("vec%0d imm", k), if_b1.out_imm, vecs[k].imm);
            chk($sformatf("vec%0d dest", k), if_b1.out_dest, vecs[k].dest);
            chk($sformatf("vec%0d dest_en", k), if_b1.out_dest_en, vecs[k].dest_en);
            chk($sformatf("vec%0d instr", k), if_b1.out_instr, vecs[k].instr);
            chk($sformatf("vec%0d pc", k), if_b1.out_pc, 16'h0100 + 16'(2 * k));
        end

        // Same-cycle writeback forwarding
        do_reset();
        instr = 16'h4360; iv1 = 1; iv0 = 1; out_ready = 1;
        wb_en = 1; wb_reg = 3'd3; wb_data = 16'hBEEF;
        smp();
        chk("byp b1 in_ready", if_b1.in_ready, 1);
        chk("byp b0 in_ready", if_b0.in_ready, 1);
        step();
        iv1 = 0; iv0 = 0; wb_en = 0;
        smp();
        chk("byp b1 rs_data", if_b1.out_rs_data, 16'hBEEF);
        chk("byp b1 rt_data", if_b1.out_rt_data, 16'hBEEF);
        chk("byp b0 rs_data", if_b0.out_rs_data, 16'h0000);
        chk("byp b1 err", if_b1.err, 1);

        // RAW hazard on R2
        do_reset();
        out_ready = 1; instr = 16'h4040; pc = 16'h0004; iv1 = 1; iv0 = 1;
        step();
        instr = 16'h0200;
        smp();
        chk("raw held b1 in_ready", if_b1.in_ready, 0);
        chk("raw held b0 in_ready", if_b0.in_ready, 0);
        step();
        for (int c = 0; c < 3; c++) begin
            smp();
            chk($sformatf("raw wait%0d b1 in_ready", c), if_b1.in_ready, 0);
            chk($sformatf("raw wait%0d b0 in_ready", c), if_b0.in_ready, 0);
            chk($sformatf("raw wait%0d b1 out_valid", c), if_b1.out_valid, 0);
            step();
        end
        wb_en = 1; wb_reg = 3'd2; wb_data = 16'h1234;
        smp();
        chk("raw wb b1 in_ready", if_b1.in_ready, 1);
        chk("raw wb b0 in_ready", if_b0.in_ready, 0);
        step();
        wb_en = 0; iv1 = 0;
        smp();
        chk("raw b1 out_valid", if_b1.out_valid, 1);
        chk("raw b1 rs_data", if_b1.out_rs_data, 16'h1234);
        chk("raw b1 instr", if_b1.out_instr, 16'h0200);
        chk("raw b0 in_ready", if_b0.in_ready, 1);
        chk("raw b0 out_valid", if_b0.out_valid, 0);
        step();
        iv0 = 0;
        smp();
        chk("raw b0 late out_valid", if_b0.out_valid, 1);
        chk("raw b0 late rs_data", if_b0.out_rs_data, 16'h1234);
        chk("raw b1 err", if_b1.err, 0);
        chk("raw b0 err", if_b0.err, 0);

        // Backpressure hold then single release
        do_reset();
        out_ready = 0; instr = 16'hC2FF; pc = 16'h0010; iv1 = 1; iv0 = 1;
        step();
        instr = 16'h0123; pc = 16'h0012;
        for (int c = 0; c < 3; c++) begin
            smp();
            chk($sformatf("hold%0d out_valid", c), if_b1.out_valid, 1);
            chk($sformatf("hold%0d instr", c), if_b1.out_instr, 16'hC2FF);
            chk($sformatf("hold%0d imm", c), if_b1.out_imm, 16'hFFFF);
            chk($sformatf("hold%0d pc", c), if_b1.out_pc, 16'h0010);
            chk($sformatf("hold%0d dest", c), if_b1.out_dest, 3'd2);
            chk($sformatf("hold%0d in_ready", c), if_b1.in_ready, 0);
            step();
        end
        out_ready = 1;
        smp();
        chk("release in_ready", if_b1.in_ready, 1);
        step();
        iv1 = 0; iv0 = 0;
        smp();
        chk("release out_valid", if_b1.out_valid, 1);
        chk("release next instr", if_b1.out_instr, 16'h0123);
        chk("release next pc", if_b1.out_pc, 16'h0012);
        step();
        smp();
        chk("release drained", if_b1.out_valid, 0);

        // Flush kills the bundle and its handoff
        do_reset();
        out_ready = 1; instr = 16'h4040; pc = 16'h0020; iv1 = 1; iv0 = 1;
        step();
        iv1 = 0; iv0 = 0; flush = 1; instr = 16'h0200;
        smp();
        chk("flush pre out_valid", if_b1.out_valid, 1);
        chk("flush in_ready", if_b1.in_ready, 0);
        step();
        flush = 0;
        smp();
        chk("flush out_valid", if_b1.out_valid, 0);
        chk("flush no inc b1", if_b1.in_ready, 1);
        chk("flush no inc b0", if_b0.in_ready, 1);
        iv1 = 1; iv0 = 1;
        step();
        iv1 = 0; iv0 = 0;
        smp();
        chk("flush after out_valid", if_b1.out_valid, 1);
        chk("flush after instr", if_b1.out_instr, 16'h0200);
        chk("flush err", if_b1.err, 0);

        // Writeback with no pending writer
        do_reset();
        wb_en = 1; wb_reg = 3'd5; wb_data = 16'h5A5A;
        smp();
        chk("orphan pre err", if_b1.err, 0);
        step();
        wb_en = 0; instr = 16'h0500; iv1 = 1; iv0 = 1; out_ready = 1;
        smp();
        chk("orphan err b1", if_b1.err, 1);
        chk("orphan err b0", if_b0.err, 1);
        chk("orphan count zero", if_b1.in_ready, 1);
        step();
        iv1 = 0; iv0 = 0;
        smp();
        chk("orphan write done", if_b1.out_rs_data, 16'h5A5A);

        // Scoreboard saturation on R1
        do_reset();
        instr = 16'hD804; out_ready = 1; iv1 = 1; iv0 = 1;
        repeat (4) step();
        iv1 = 0; iv0 = 0; instr = 16'h0100;
        smp();
        chk("sat pre err", if_b1.err, 0);
        chk("sat pre in_ready", if_b1.in_ready, 0);
        step();
        smp();
        chk("sat err b1", if_b1.err, 1);
        chk("sat err b0", if_b0.err, 1);
        wb_en = 1; wb_reg = 3'd1; wb_data = 16'h0011;
        step();
        step();
        wb_en = 0;
        smp();
        chk("sat one left b1", if_b1.in_ready, 0);
        chk("sat one left b0", if_b0.in_ready, 0);
        wb_en = 1;
        step();
        wb_en = 0;
        smp();
        chk("sat empty b1", if_b1.in_ready, 1);
        chk("sat empty b0", if_b0.in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
Parametrised, pipelined decode stage for the 16-bit core.
- Holds the register file and extracts sources, destination and sign-extended immediate from the fetched instruction.
- Tracks in-flight destinations in a scoreboard and stalls on read-after-write hazards.
- Presents a registered, valid/ready-handshaked bundle to execute, replacing the combinational decode path.

Parameters:
DATA_W, 16, register/datapath width (>=16)
SB_W, 2, per-register scoreboard counter width (max in-flight writers = 2^SB_W-1)
BYPASS, 1, 1 = same-cycle writeback forwarded to reads and hazard check; 0 = no forwarding

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  fetch bundle valid
in_ready  out  1  decode can accept this cycle
in_instr  in  16  instruction
in_pc  in  DATA_W  PC+2 of instruction
wb_en  in  1  writeback strobe
wb_reg  in  3  writeback register
wb_data  in  DATA_W  writeback data
flush  in  1  synchronous kill of the output bundle
out_valid  out  1  output bundle valid
out_ready  in  1  execute accepts bundle
out_rs_data  out  DATA_W  R[instr[10:8]]
out_rt_data  out  DATA_W  R[instr[7:5]]
out_imm  out  DATA_W  sign-extended immediate
out_dest  out  3  destination register
out_dest_en  out  1  instruction writes a register
out_instr  out  16  instruction passthrough
out_pc  out  DATA_W  PC passthrough
err  out  1  sticky error

Behaviour:
- Reset (rst low, asynchronous):
  - All 8 registers, all outputs and all scoreboard counters go to 0.
  - err goes to 0.
- Register file:
  - 8 x DATA_W.
  - Written on a rising edge when wb_en is high.
  - R0 is an ordinary register.
  - Reads are combinational into the output register.
  - BYPASS=1: if wb_en is high and wb_reg matches a source, the read returns wb_data.
- Field decode:
  - Destination: instr[15:11]==5'b11011 -> instr[4:2]; instr[15:13] in {3'b010, 3'b101} -> instr[7:5]; else instr[10:8].
  - Immediate: instr[15:13] in {3'b110, 3'b001} -> sext(instr[7:0]); else sext(instr[4:0]); sign-extended to DATA_W.
  - dest_en = 0 for instr[15:13]==3'b011 and for instr[15:11] in {5'b00000, 5'b10000}; 1 otherwise.
- Handshake:
  - Output is a single register stage.
  - Accept occurs when in_valid && in_ready.
  - in_ready = (!out_valid || out_ready) && !stall && !flush.
  - A held bundle stays stable while out_valid && !out_ready.
  - Latency: accept at edge N gives out_valid high after edge N.
- Scoreboard:
  - One SB_W counter per register.
  - Increment on output handshake (out_valid && out_ready && out_dest_en) for out_dest.
  - Decrement on wb_en for wb_reg.
  - Simultaneous increment and decrement on the same register leaves the count unchanged.
- Hazard stall: stall = 1 if, for either source s (rs, rt, always checked):
  - eff(s) > 0, where eff = count[s] - (BYPASS && wb_en && wb_reg==s), or
  - out_valid && out_dest_en && out_dest==s (a producer is still held in decode).
- flush:
  - Clears out_valid on the next edge.
  - Does not touch the scoreboard or the register file.
  - Blocks accept in that cycle.
  - flush wins over a pending out_ready handshake (no increment).
- err: set and held until reset on either condition:
  - wb_en with count[wb_reg]==0 (write is still performed, counter stays 0);
  - increment at max count (counter saturates).

Test Plan:
- Reset then drive in_instr=16'h4000 (imm5, dest=R0, reads R0/R0) with out_ready=1 -> out_valid next cycle, out_rs_data=0, out_imm=0, err=0.
- wb_en with R3=16'hBEEF while decoding an instruction with rs=R3, BYPASS=1 -> out_rs_data=16'hBEEF in the same bundle. BYPASS=0 -> old value 0.
- Producer writing R2 handed off, then consumer reading R2 -> in_ready=0 until wb_en,wb_reg=2. Consumer is accepted the same cycle as wb (BYPASS=1) or the cycle after (BYPASS=0).
- Hold out_ready=0 for 3 cycles with a bundle present -> all out_* stable and in_ready=0. Release -> one handshake, no duplication.
- flush asserted with out_valid=1, out_ready=1 -> out_valid=0 next cycle and the scoreboard count is unchanged.
- wb_en to R5 with count 0 -> err=1, R5 still updated, count stays 0. Four handoffs to R1 with SB_W=2 -> count saturates at 3, err=1.
